// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider with tick strobes
module clk_div_multi #(
    parameter  int NUM_CH  = 2,
    parameter  int CNT_W   = 32,
    parameter  int DEF_DIV = 200000,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_clr,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_shadow;
        logic [CNT_W-1:0] r_active;
        logic [CNT_W-1:0] r_cnt;
        logic             r_en_d;
        logic             r_clk;
        logic             r_tick;

        logic             w_wr_hit;
        logic             w_rise;
        logic             w_wrap;
        logic [CNT_W-1:0] w_cnt_inc;
        logic [CNT_W-1:0] w_low_len;

        // Out-of-range channel numbers never match any g, so they are dropped.
        assign w_wr_hit  = wr_en && (wr_ch == CH_W'(g));
        assign w_rise    = ch_en[g] && !r_en_d;
        assign w_wrap    = (r_active != '0) && (r_cnt == r_active - CNT_W'(1));
        assign w_cnt_inc = r_cnt + CNT_W'(1);
        assign w_low_len = r_active - (r_active >> 1);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_shadow <= CNT_W'(DEF_DIV);
                r_active <= CNT_W'(DEF_DIV);
                r_cnt    <= '0;
                r_en_d   <= 1'b0;
                r_clk    <= 1'b0;
                r_tick   <= 1'b0;
            end else begin
                r_en_d <= ch_en[g];
                if (w_wr_hit) begin
                    r_shadow <= wr_div;
                end
                // Reloads read the pre-write shadow, so a same-edge write waits a period.
                if (sync_clr) begin
                    r_active <= r_shadow;
                    r_cnt    <= '0;
                    r_clk    <= 1'b0;
                    r_tick   <= 1'b0;
                end else if (!ch_en[g]) begin
                    r_cnt    <= '0;
                    r_clk    <= 1'b0;
                    r_tick   <= 1'b0;
                end else if (w_rise) begin
                    r_active <= r_shadow;
                    r_cnt    <= '0;
                    r_clk    <= 1'b0;
                    r_tick   <= 1'b0;
                end else if (r_active == '0) begin
                    r_cnt    <= '0;
                    r_clk    <= 1'b0;
                    r_tick   <= 1'b0;
                end else if (w_wrap) begin
                    r_active <= r_shadow;
                    r_cnt    <= '0;
                    r_clk    <= 1'b0;
                    r_tick   <= 1'b1;
                end else begin
                    r_cnt    <= w_cnt_inc;
                    r_clk    <= (w_cnt_inc >= w_low_len);
                    r_tick   <= 1'b0;
                end
            end
        end

        assign clk_out[g] = r_clk;
        assign tick[g]    = r_tick;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed self-checking bench for clk_div_multi
module tb_clk_div_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ch_en;
    logic        sync_clr;
    logic        wr_en;
    logic [0:0]  wr_ch;
    logic [15:0] wr_div;
    logic [1:0]  clk_out;
    logic [1:0]  tick;

    int checks = 0;
    int errors = 0;

    clk_div_multi #(
        .NUM_CH (2),
        .CNT_W  (16),
        .DEF_DIV(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ch_en   (ch_en),
        .sync_clr(sync_clr),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    // Expected {ch1,ch0} per cycle, hand-derived
    logic [1:0] odd_clk  [9]  = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] odd_tick [9]  = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
    logic [1:0] bnd_clk  [13] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00,
                                  2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
    logic [1:0] bnd_tick [13] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01,
                                  2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
    logic [1:0] pa_clk   [8]  = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00};
    logic [1:0] pa_tick  [8]  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Eight enabled cycles of a fresh divide-by-4 period on both channels
    task automatic run_nominal(input string tag);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("%s_clk_%0d", tag, i), clk_out, (((i - 1) % 4) >= 2) ? 2'b11 : 2'b00);
            chk($sformatf("%s_tick_%0d", tag, i), tick, (i == 5) ? 2'b11 : 2'b00);
        end
    endtask

    initial begin
        rst      = 1'b1;
        ch_en    = 2'b00;
        sync_clr = 1'b0;
        wr_en    = 1'b0;
        wr_ch    = 1'b0;
        wr_div   = 16'd0;
        step();
        step();
        chk("reset_clk", clk_out, 2'b00);
        chk("reset_tick", tick, 2'b00);

        rst   = 1'b0;
        ch_en = 2'b11;
        run_nominal("nominal");
        step();
        chk("nominal_clk_9", clk_out, 2'b00);
        chk("nominal_tick_9", tick, 2'b11);

        wr_en  = 1'b1;
        wr_ch  = 1'b1;
        wr_div = 16'd5;
        for (int k = 0; k < 9; k++) begin
            step();
            wr_en = 1'b0;
            chk($sformatf("odd_clk_%0d", k), clk_out, odd_clk[k]);
            chk($sformatf("odd_tick_%0d", k), tick, odd_tick[k]);
        end

        for (int j = 0; j < 13; j++) begin
            if (j == 2) begin
                wr_en  = 1'b1;
                wr_ch  = 1'b0;
                wr_div = 16'd6;
            end
            step();
            wr_en = 1'b0;
            chk($sformatf("bnd_clk_%0d", j), clk_out, bnd_clk[j]);
            chk($sformatf("bnd_tick_%0d", j), tick, bnd_tick[j]);
        end

        wr_en  = 1'b1;
        wr_ch  = 1'b0;
        wr_div = 16'd4;
        step();
        wr_ch  = 1'b1;
        wr_div = 16'd8;
        step();
        wr_en    = 1'b0;
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        chk("align_clr_clk", clk_out, 2'b00);
        chk("align_clr_tick", tick, 2'b00);
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("align_clk_%0d", k), clk_out, pa_clk[k]);
            chk($sformatf("align_tick_%0d", k), tick, pa_tick[k]);
        end

        step();
        step();
        chk("pre_drop_clk0", {1'b0, clk_out[0]}, 2'b01);
        ch_en = 2'b10;
        step();
        chk("drop_clk0", {1'b0, clk_out[0]}, 2'b00);
        chk("drop_tick0", {1'b0, tick[0]}, 2'b00);

        wr_en  = 1'b1;
        wr_ch  = 1'b0;
        wr_div = 16'd1;
        step();
        wr_en = 1'b0;
        chk("off_clk0", {1'b0, clk_out[0]}, 2'b00);
        ch_en = 2'b11;
        step();
        chk("div1_first_tick0", {1'b0, tick[0]}, 2'b00);
        chk("div1_first_clk0", {1'b0, clk_out[0]}, 2'b00);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("div1_tick0_%0d", k), {1'b0, tick[0]}, 2'b01);
            chk($sformatf("div1_clk0_%0d", k), {1'b0, clk_out[0]}, 2'b00);
        end

        wr_en  = 1'b1;
        wr_ch  = 1'b0;
        wr_div = 16'd0;
        step();
        wr_en    = 1'b0;
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        chk("div0_clr_tick0", {1'b0, tick[0]}, 2'b00);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                wr_en  = 1'b1;
                wr_ch  = 1'b1;
                wr_div = 16'd10;
            end
            step();
            wr_en = 1'b0;
            chk($sformatf("div0_tick0_%0d", k), {1'b0, tick[0]}, 2'b00);
            chk($sformatf("div0_clk0_%0d", k), {1'b0, clk_out[0]}, 2'b00);
        end
        chk("pre_rst_clk1", {1'b0, clk_out[1]}, 2'b01);

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_clk", clk_out, 2'b00);
        chk("midrst_tick", tick, 2'b00);
        run_nominal("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised successor to the fixed two-output clock divider: NUM_CH independent divider channels, each with a divisor that is programmable at run time.
- Each channel produces a registered square-wave output and a one-cycle tick strobe.
- Also provides per-channel enable and a global phase-align clear.
- Sits beside the system clock root and feeds scan, debounce and timer logic with clock-enable strobes, so those blocks need no derived clocks.

Parameters:
- NUM_CH, 2, number of divider channels (1..16).
- CNT_W, 32, width of each counter and divisor.
- DEF_DIV, 200000, divisor loaded into every channel at reset: full output period in clk cycles.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ch_en  in  NUM_CH  per-channel run enable.
- sync_clr  in  1  restarts all channels at phase 0 in the same cycle.
- wr_en  in  1  divisor write strobe.
- wr_ch  in  CH_W  target channel. CH_W = max(1, clog2(NUM_CH)).
- wr_div  in  CNT_W  new divisor value.
- clk_out  out  NUM_CH  square-wave output per channel, registered.
- tick  out  NUM_CH  one-cycle strobe per completed period, registered.

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst. No asynchronous paths.
- Per-channel state:
  - shadow divisor, written via the write port;
  - active divisor, which sets the period in use;
  - counter cnt.
- Reset:
  - shadow = active = DEF_DIV for every channel;
  - cnt = 0;
  - clk_out = 0 and tick = 0 for all channels.
- Write port:
  - wr_en=1 with wr_ch < NUM_CH sets shadow[wr_ch] <= wr_div at the clock edge.
  - wr_ch >= NUM_CH is ignored.
  - A write never changes active or cnt directly.
- Active divisor reload: active <= shadow occurs only at a period boundary (cnt == active-1 while enabled), on sync_clr, or on a rising ch_en.
  - If a write lands on the same edge as the reload, the reload takes the pre-write shadow value. The written value is applied at the next boundary.
- Counting, when ch_en=1 and active >= 1:
  - cnt increments by 1 per clk.
  - At cnt == active-1 the next value is 0 (wrap).
  - tick <= 1 on the wrap edge, 0 otherwise. tick is therefore high for exactly one cycle, coincident with cnt == 0 after a wrap.
  - No tick occurs at reset, at enable, or at sync_clr start.
- Square wave: clk_out[i] is registered and equals (next cnt >= active - (active>>1)).
  - Low for ceil(div/2) cycles, high for floor(div/2) cycles, starting low.
  - div=2 gives clk/2. div=5 gives 3 low, 2 high.
- active == 1: cnt stays 0, tick is high every cycle from the 2nd enabled cycle onward, clk_out stays 0.
- active == 0: channel halted, cnt held at 0, clk_out=0, tick=0. A non-zero shadow value is applied only via sync_clr or an enable toggle.
- ch_en[i]=0: cnt <= 0, clk_out <= 0, tick <= 0 on the next edge. Re-enabling starts a fresh period at phase 0 and reloads active from shadow.
- sync_clr=1 (all channels):
  - cnt <= 0, active <= shadow, clk_out <= 0, tick <= 0.
  - Takes priority over counting and over enable edges.
  - Only rst has higher priority.
- Priority order: rst > sync_clr > ch_en low > count/wrap.
- Counter arithmetic is CNT_W bits unsigned. Compare with active-1 only when active >= 1.
- No overflow is possible, since cnt < active <= 2^CNT_W - 1.

Test Plan:
- Nominal period: NUM_CH=2, DEF_DIV=4, rst pulse then ch_en=2'b11 → clk_out pattern 0,0,1,1 repeating; tick high every 4th cycle, first at enabled cycle 5.
- Odd divisor with runtime update: write ch1 wr_div=5 mid-period → ch1 finishes its current 4-cycle period, then runs at 3 low / 2 high with tick every 5 cycles; ch0 is unaffected.
- Write on a boundary: wr_en on the exact wrap edge with wr_div=6 → the next period stays 4 and the following period is 6.
- Phase align: ch0 div=4, ch1 div=8 with offset phases; assert sync_clr one cycle → both cnt=0 next cycle, and both ticks coincide 8 cycles later.
- Enable and degenerate divisors: drop ch_en[0] mid-high phase → clk_out[0]=0 next cycle with no tick. Write div=1 then re-enable → tick is high continuously from cycle 2 and clk_out stays 0. Write div=0 plus sync_clr → channel is silent.
- Reset mid-operation: assert rst during a high phase after writing shadow=10 → next cycle all outputs are 0 and divisors are back to DEF_DIV=4; the 10 is discarded.
